// File: rtl/round_requant_pipe.sv
// Two-stage requantiser: stage 1 shifts and rounds each lane at IN_W+1 bits,
// stage 2 saturates to OUT_W and presents the beat on a valid/ready stream.
module round_requant_pipe #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int CH      = 2,
  parameter int SHIFT_W = 4,
  parameter int SAT_SYM = 0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*IN_W-1:0]   in_data,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic [1:0]           in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*OUT_W-1:0]  out_data,
  output logic [CH-1:0]        out_sat,
  output logic                 out_last,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     sat_cnt
);

  typedef enum logic [1:0] {
    M_TRUNC     = 2'd0,
    M_HALF_UP   = 2'd1,
    M_HALF_AWAY = 2'd2,
    M_HALF_EVEN = 2'd3
  } mode_e;

  localparam int RW   = IN_W + 1;
  localparam int SMAX = IN_W - 1;

  localparam logic signed [IN_W:0] POS_LIM = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] NEG_LIM = (SAT_SYM != 0) ? -POS_LIM
                                                           : -POS_LIM - RW'(1);

  // Floor shift plus a mode-dependent increment; one extra bit keeps the
  // round-up carry of the most positive input from wrapping.
  function automatic logic [IN_W:0] round_lane(input logic [IN_W-1:0] x,
                                               input logic [SHIFT_W-1:0] s,
                                               input mode_e mode);
    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] q;
    logic [IN_W:0]        r;
    logic [IN_W:0]        half;
    logic                 inc;
    xe   = $signed({x[IN_W-1], x});
    q    = xe >>> s;
    r    = xe & ~({RW{1'b1}} << s);
    half = (RW'(1) << s) >> 1;
    inc  = 1'b0;
    if (s != '0) begin
      case (mode)
        M_TRUNC:     inc = 1'b0;
        M_HALF_UP:   inc = (r >= half);
        M_HALF_AWAY: inc = xe[IN_W] ? (r > half) : (r >= half);
        M_HALF_EVEN: inc = (r > half) || ((r == half) && q[0]);
        default:     inc = 1'b0;
      endcase
    end
    return q + RW'(inc);
  endfunction

  // Returns {sat_flag, clipped_value}.
  function automatic logic [OUT_W:0] sat_lane(input logic signed [IN_W:0] v);
    if (v > POS_LIM) begin
      return {1'b1, POS_LIM[OUT_W-1:0]};
    end else if (v < NEG_LIM) begin
      return {1'b1, NEG_LIM[OUT_W-1:0]};
    end
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [SHIFT_W-1:0]   shift_c;
  logic [CH*RW-1:0]     rnd;
  logic                 s1_valid;
  logic [CH*RW-1:0]     s1_val;
  logic                 s1_last;
  logic                 s2_load;
  logic [CH*OUT_W-1:0]  sat_data;
  logic [CH-1:0]        sat_flag;

  always_comb begin
    shift_c = (in_shift > SHIFT_W'(SMAX)) ? SHIFT_W'(SMAX) : in_shift;
  end

  always_comb begin
    rnd = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      rnd[k*RW +: RW] = round_lane(in_data[k*IN_W +: IN_W], shift_c,
                                   mode_e'(in_mode));
    end
  end

  always_comb begin
    s2_load  = !out_valid || out_ready;
    in_ready = !rst && (!s1_valid || s2_load);
  end

  // Stage 1: rounded lanes at full precision.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val  <= rnd;
        s1_last <= in_last;
      end
    end
  end

  always_comb begin
    sat_data = '0;
    sat_flag = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      {sat_flag[k], sat_data[k*OUT_W +: OUT_W]} =
        sat_lane($signed(s1_val[k*RW +: RW]));
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      out_last  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_data;
        out_sat  <= sat_flag;
        out_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && (|out_sat) && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_round_requant_pipe.sv
// Scoreboard bench: a real-arithmetic rounding model predicts every beat for two
// instances (asymmetric 16-bit counter / symmetric limit with 2-bit counter).
module tb_round_requant_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready, cnt_clr;
  logic        in_ready, in_ready1, out_valid, out_valid1, out_last, out_last1;
  logic [31:0] in_data;
  logic [4:0]  in_shift;
  logic [1:0]  in_mode;
  logic [15:0] out_data, out_data1;
  logic [1:0]  out_sat, out_sat1;
  logic [15:0] sat_cnt;
  logic [1:0]  sat_cnt1;

  always #5 clk = ~clk;

  round_requant_pipe #(.IN_W(16), .OUT_W(8), .CH(2), .SHIFT_W(4), .SAT_SYM(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift[3:0]), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_last(out_last), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt));

  round_requant_pipe #(.IN_W(16), .OUT_W(8), .CH(2), .SHIFT_W(5), .SAT_SYM(1), .CNT_W(2)) dut_sym (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_sat(out_sat1), .out_last(out_last1), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt1));

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt0  = 0;
  int   cnt1  = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value / 2**s as a real number, rounded by the mode's rule.
  function automatic void ref_lane(input int x, input int sh, input int md, input bit sym,
                                   output int y, output bit sat);
    int  s;
    real p, v, f;
    int  r;
    s = (sh > 15) ? 15 : sh;
    p = 1.0;
    for (int i = 0; i < s; i++) p = p * 2.0;
    v = x / p;
    f = $floor(v);
    case (md)
      0: r = $rtoi(f);
      1: r = $rtoi($floor(v + 0.5));
      2: r = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : $rtoi($ceil(v - 0.5));
      default: begin
        if (v - f > 0.5) r = $rtoi(f) + 1;
        else if (v - f == 0.5) r = ($rtoi(f) % 2 == 0) ? $rtoi(f) : $rtoi(f) + 1;
        else r = $rtoi(f);
      end
    endcase
    sat = 1'b1;
    if (r > 127) y = 127;
    else if (r < (sym ? -127 : -128)) y = sym ? -127 : -128;
    else begin
      y = r;
      sat = 1'b0;
    end
  endfunction

  function automatic exp_t make_exp(input logic [31:0] d, input int sh, input int md, input bit last);
    exp_t e;
    int   x, y;
    bit   s;
    e = '0;
    e.last = last;
    for (int k = 0; k < 2; k++) begin
      x = int'($signed(d[k*16 +: 16]));
      ref_lane(x, sh % 16, md, 1'b0, y, s);
      e.d0[k*8 +: 8] = y[7:0];
      e.s0[k] = s;
      ref_lane(x, sh, md, 1'b1, y, s);
      e.d1[k*8 +: 8] = y[7:0];
      e.s1[k] = s;
    end
    return e;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at posedge+1; the expectation is queued once acceptance is certain.
  task automatic send(input logic [31:0] d, input int sh, input int md, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 5'(sh);
    in_mode  = 2'(md);
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        q.push_back(make_exp(d, sh, md, last));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: in_ready never seen, got 0 expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !out_valid) return;
      cycles(1);
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented beat must match the queue head; it pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    hs = 1'b0;
    e  = '0;
    chk("sat_cnt", 32'(sat_cnt), 32'(cnt0));
    chk("sat_cnt_sym", 32'(sat_cnt1), 32'(cnt1));
    if (rst) begin
      chk("in_ready_rst", 32'(in_ready), 32'd0);
      q.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      chk("in_ready_sym", 32'(in_ready1), 32'((q.size() < 2) || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_beat: out_data 0x%0h with empty scoreboard, expected none", out_data);
        end else begin
          e = q[0];
          chk("out_data", 32'(out_data), 32'(e.d0));
          chk("out_sat", 32'(out_sat), 32'(e.s0));
          chk("out_last", 32'(out_last), 32'(e.last));
          chk("out_valid_sym", 32'(out_valid1), 32'd1);
          chk("out_data_sym", 32'(out_data1), 32'(e.d1));
          chk("out_sat_sym", 32'(out_sat1), 32'(e.s1));
          chk("out_last_sym", 32'(out_last1), 32'(e.last));
          if (out_ready) begin
            hs = 1'b1;
            void'(q.pop_front());
          end
        end
      end
    end
    if (rst || cnt_clr) begin
      cnt0 = 0;
      cnt1 = 0;
    end else if (hs) begin
      if (|e.s0 && cnt0 < 65535) cnt0++;
      if (|e.s1 && cnt1 < 3) cnt1++;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0;
    in_mode = '0; in_last = 1'b0; cnt_clr = 1'b0;
    cycles(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    cycles(2);

    // Latency into an empty pipe with the consumer ready.
    send(32'hFE80_0180, 8, 3, 1'b1);
    chk("latency_1", 32'(out_valid), 32'd0);
    cycles(1);
    chk("latency_2", 32'(out_valid), 32'd1);
    drain();

    send(32'h0181_0280, 8, 3, 1'b0);
    for (int m = 0; m < 4; m++) send(32'hFE80_0180, 8, m, 1'(m & 1));
    for (int m = 0; m < 4; m++) begin
      send(32'h8000_7FFF, 15, m, 1'b0);
      send(32'h8000_7FFF, 20, m, 1'b1);
      send(32'hFE80_0180, 31, m, 1'b0);
    end
    send(32'h8000_0100, 0, 0, 1'b0);
    send(32'h7FFF_8000, 8, 1, 1'b1);
    send(32'hFF80_007F, 0, 2, 1'b0);
    send(32'h8001_7FFF, 0, 3, 1'b0);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i % 3 == 0) d = {16'($signed(10'($urandom))), 16'($signed(10'($urandom)))};
      send(d, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    drain();

    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    repeat (3) send(32'h0100_8000, 0, 0, 1'b0);
    drain();
    cycles(1);
    chk("cnt_three", 32'(sat_cnt), 32'd3);
    cnt_clr = 1'b1;
    send(32'h0100_8000, 0, 0, 1'b0);
    drain();
    cnt_clr = 1'b0;
    cycles(1);
    chk("cnt_clr_wins", 32'(sat_cnt), 32'd0);
    repeat (5) send(32'h0100_0100, 0, 1, 1'b1);
    drain();
    cycles(1);
    chk("cnt_five", 32'(sat_cnt), 32'd5);
    chk("cnt_hold_w2", 32'(sat_cnt1), 32'd3);

    // Reset with two beats in flight behind a stalled consumer.
    rdy_mode = 2;
    cycles(2);
    send(32'h0100_0100, 0, 0, 1'b1);
    send(32'h0200_0300, 4, 1, 1'b0);
    rst = 1'b1;
    cycles(1);
    chk("rst_flush_valid", 32'(out_valid), 32'd0);
    chk("rst_flush_cnt", 32'(sat_cnt), 32'd0);
    rst = 1'b0;
    rdy_mode = 0;
    cycles(6);
    chk("no_stale_beat", 32'(out_valid), 32'd0);
    send(32'h0280_FE80, 8, 3, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
